// File: rtl/tone_synth_pkg.sv
// Shared types, default widths and the base half-period table for tone_synth_gen.
package tone_synth_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int NOTE_W_DEF = 3;
  localparam int OCT_W_DEF  = 2;
  localparam int NUM_NOTES  = 2 ** NOTE_W_DEF;
  localparam int BASE_W     = 16;

  typedef enum logic [NOTE_W_DEF-1:0] {DO_L, RE, MI, FA, SO, LA, SI, DO_H} note_e;

  typedef enum logic {IDLE, RUN} state_e;

  // Half-period divisors at 50 MHz for the lowest octave, indexed by note_e.
  localparam logic [BASE_W-1:0] BASE_DIV [NUM_NOTES] = '{
    16'd47801, 16'd42589, 16'd37936, 16'd35816,
    16'd31928, 16'd28409, 16'd25329, 16'd23900
  };

endpackage

// File: rtl/tone_period_counter.sv
// Half-period counter: counts up to i_div-1 while running and strobes each toggle;
// a toggle taken while the output is high is the period boundary.
module tone_period_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_phase,
  output logic             o_toggle,
  output logic             o_boundary
);

  logic [CNT_W-1:0] r_count;
  logic             w_hit;

  assign w_hit      = i_run && (r_count == i_div - CNT_W'(1));
  assign o_toggle   = w_hit;
  assign o_boundary = w_hit && i_phase;

  // NOTE: reset is synchronous, so it is just the first branch of the clocked if-chain.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_run) begin
      r_count <= '0;
    end else if (w_hit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tone_synth_gen.sv
// Square-wave tone generator with octave shift, run/stop FSM and boundary-aligned note changes.
// Optional macro TONE_SYNTH_PERIOD_CNT_EN adds the period_cnt output.
module tone_synth_gen
  import tone_synth_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int OCT_W  = OCT_W_DEF
) (
  input  logic              inclk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] sel,
  input  logic [OCT_W-1:0]  octave,
  input  logic              enable,
  output logic              outclk,
  output logic              busy,
  output logic              note_ack
`ifdef TONE_SYNTH_PERIOD_CNT_EN
  ,
  output logic [15:0]       period_cnt
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cur_div;
  logic             r_outclk;
  logic             r_busy;
  logic             r_note_ack;
  logic             w_load;
  logic             w_toggle;
  logic             w_boundary;
  logic [CNT_W-1:0] w_shifted;
  logic [CNT_W-1:0] w_div;

  // Candidate half-period from the live inputs; it is only captured on a load.
  assign w_shifted = CNT_W'(BASE_DIV[sel]) >> octave;
  assign w_div     = (w_shifted == '0) ? CNT_W'(1) : w_shifted;

  tone_period_counter #(
    .CNT_W (CNT_W)
  ) u_period_counter (
    .i_clk      (inclk),
    .i_rst_n    (reset),
    .i_run      (r_state == RUN),
    .i_div      (r_cur_div),
    .i_phase    (r_outclk),
    .o_toggle   (w_toggle),
    .o_boundary (w_boundary)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (w_boundary) begin
          if (!enable) begin
            w_state_nxt = IDLE;
          end else if (w_div != r_cur_div) begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge inclk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cur_div  <= CNT_W'(BASE_DIV[DO_L]);
      r_outclk   <= 1'b0;
      r_busy     <= 1'b0;
      r_note_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt == RUN);
      r_note_ack <= w_load;
      if (w_load) begin
        r_cur_div <= w_div;
      end
      // The stop boundary is a 1->0 toggle, so the output always lands low in IDLE.
      if (w_toggle) begin
        r_outclk <= ~r_outclk;
      end
    end
  end

  assign outclk   = r_outclk;
  assign busy     = r_busy;
  assign note_ack = r_note_ack;

`ifdef TONE_SYNTH_PERIOD_CNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge inclk) begin
    if (!reset) begin
      r_period_cnt <= '0;
    end else if ((r_state == IDLE) && (w_state_nxt == RUN)) begin
      r_period_cnt <= '0;
    end else if (w_boundary) begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule
